// File: rtl/vram_write_scheduler.sv
// Arbitrates two pixel writers and a full-screen clear sweep onto one video RAM write port.
// Optional macro VRAM_BLANK_ONLY_EN restricts grants and clear writes to blanking cycles.
module vram_write_scheduler #(
  parameter logic [7:0] MAX_COL = 8'd159,
  parameter logic [7:0] MAX_ROW = 8'd119,
  localparam int unsigned COORD_W = 8,
  localparam int unsigned RGB_W = 3
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               iReq0,
  input  logic [COORD_W-1:0] iRow0,
  input  logic [COORD_W-1:0] iCol0,
  input  logic [RGB_W-1:0]   iRGB0,
  output logic               oAck0,
  input  logic               iReq1,
  input  logic [COORD_W-1:0] iRow1,
  input  logic [COORD_W-1:0] iCol1,
  input  logic [RGB_W-1:0]   iRGB1,
  output logic               oAck1,
  input  logic               iClearReq,
  input  logic [RGB_W-1:0]   iClearColor,
  input  logic               iBlank,
  output logic               oWriteEnable,
  output logic [COORD_W-1:0] oWriteRow,
  output logic [COORD_W-1:0] oWriteCol,
  output logic [RGB_W-1:0]   oRGB,
  output logic               oBusy
);

  typedef struct packed {
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
    logic [RGB_W-1:0]   rgb;
  } pixel_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t             state;
  state_t             stateNext;
  logic [COORD_W-1:0] rowCnt;
  logic [COORD_W-1:0] colCnt;
  logic [COORD_W-1:0] rowCntNext;
  logic [COORD_W-1:0] colCntNext;
  logic [RGB_W-1:0]   clearColor;
  logic [RGB_W-1:0]   clearColorNext;
  logic               lastGrant;
  logic               lastGrantNext;
  pixel_t             pixel;
  pixel_t             pixelNext;
  logic               writeEnableNext;
  logic               ack0Next;
  logic               ack1Next;
  logic               busyNext;
  logic               writeSlot;
  logic               elig0;
  logic               elig1;
  logic               grant0;
  logic               grant1;

  // Edges on which a write may be issued
`ifdef VRAM_BLANK_ONLY_EN
  assign writeSlot = iBlank;
`else
  logic unusedBlank;
  assign unusedBlank = iBlank;
  assign writeSlot   = 1'b1;
`endif

  // A requester sits out its own ack cycle so a held request is not written twice
  assign elig0  = iReq0 & ~oAck0 & writeSlot & (state == IDLE) & ~iClearReq;
  assign elig1  = iReq1 & ~oAck1 & writeSlot & (state == IDLE) & ~iClearReq;
  assign grant0 = elig0 & (~elig1 | lastGrant);
  assign grant1 = elig1 & (~elig0 | ~lastGrant);

  // State and output registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state        <= IDLE;
      rowCnt       <= '0;
      colCnt       <= '0;
      clearColor   <= '0;
      lastGrant    <= 1'b1;
      pixel        <= '0;
      oWriteEnable <= 1'b0;
      oAck0        <= 1'b0;
      oAck1        <= 1'b0;
      oBusy        <= 1'b0;
    end else begin
      state        <= stateNext;
      rowCnt       <= rowCntNext;
      colCnt       <= colCntNext;
      clearColor   <= clearColorNext;
      lastGrant    <= lastGrantNext;
      pixel        <= pixelNext;
      oWriteEnable <= writeEnableNext;
      oAck0        <= ack0Next;
      oAck1        <= ack1Next;
      oBusy        <= busyNext;
    end
  end

  assign oWriteRow = pixel.row;
  assign oWriteCol = pixel.col;
  assign oRGB      = pixel.rgb;

  // Next-state: clear entry, raster sweep and round-robin pointer
  always_comb begin
    stateNext      = state;
    rowCntNext     = rowCnt;
    colCntNext     = colCnt;
    clearColorNext = clearColor;
    lastGrantNext  = lastGrant;
    case (state)
      IDLE: begin
        if (iClearReq) begin
          stateNext      = CLEAR;
          rowCntNext     = '0;
          colCntNext     = '0;
          clearColorNext = iClearColor;
        end else if (grant0) begin
          lastGrantNext = 1'b0;
        end else if (grant1) begin
          lastGrantNext = 1'b1;
        end
      end
      CLEAR: begin
        if (writeSlot) begin
          if (colCnt == MAX_COL) begin
            colCntNext = '0;
            if (rowCnt == MAX_ROW) begin
              stateNext  = IDLE;
              rowCntNext = '0;
            end else begin
              rowCntNext = rowCnt + COORD_W'(1);
            end
          end else begin
            colCntNext = colCnt + COORD_W'(1);
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Output decode: write port contents, acks and busy for the next cycle
  always_comb begin
    writeEnableNext = 1'b0;
    ack0Next        = 1'b0;
    ack1Next        = 1'b0;
    pixelNext       = pixel;
    busyNext        = (stateNext == CLEAR);
    case (state)
      IDLE: begin
        if (grant0) begin
          writeEnableNext = 1'b1;
          ack0Next        = 1'b1;
          pixelNext       = '{row: iRow0, col: iCol0, rgb: iRGB0};
        end else if (grant1) begin
          writeEnableNext = 1'b1;
          ack1Next        = 1'b1;
          pixelNext       = '{row: iRow1, col: iCol1, rgb: iRGB1};
        end
      end
      CLEAR: begin
        if (writeSlot) begin
          writeEnableNext = 1'b1;
          pixelNext       = '{row: rowCnt, col: colCnt, rgb: clearColor};
        end
      end
      default: begin
        writeEnableNext = 1'b0;
      end
    endcase
  end

`ifndef SYNTHESIS
  // Acks are exclusive and always accompany a write
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      assert (!(oAck0 && oAck1));
      assert (!(oAck0 || oAck1) || oWriteEnable);
    end
  end
`endif

endmodule
